// File: rtl/dbg_mailbox.sv
// Two-port debug mailbox register file plus per-bit multi-stage synchronizer with rise detect.
// Read latency 1 cycle, synchronizer latency SYNC_STAGES edges; no backpressure, every port is always ready.
module dbg_mailbox #(
    parameter int ADDR_BITS   = 2,
    parameter int DATA_BITS   = 32,
    parameter int SYNC_WIDTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  addr_a,
    input  logic [DATA_BITS-1:0]  din_a,
    input  logic                  wr_en_a,
    output logic [DATA_BITS-1:0]  dout_a,
    input  logic [ADDR_BITS-1:0]  addr_b,
    input  logic [DATA_BITS-1:0]  din_b,
    input  logic                  wr_en_b,
    output logic [DATA_BITS-1:0]  dout_b,
    input  logic [SYNC_WIDTH-1:0] async_in,
    output logic [SYNC_WIDTH-1:0] sync_out,
    output logic [SYNC_WIDTH-1:0] sync_rise
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0]  mem [DEPTH] = '{default: '0};
    logic [SYNC_WIDTH-1:0] stage [SYNC_STAGES];
    logic [SYNC_WIDTH-1:0] hist;

    // Contents survive reset; port B is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (wr_en_a) mem[addr_a] <= din_a;
        if (wr_en_b) mem[addr_b] <= din_b;
    end

    // Nonblocking reads of mem give read-first behaviour on both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            hist <= '0;
        end else begin
            stage[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            hist <= stage[SYNC_STAGES-1];
        end
    end

    assign sync_out  = stage[SYNC_STAGES-1];
    assign sync_rise = sync_out & ~hist;

endmodule

// File: tb/tb_dbg_mailbox.sv
// Randomized and directed check of dbg_mailbox against a behavioural memory and delay-line model.
module tb_dbg_mailbox;
    localparam int AB = 2;
    localparam int DB = 32;
    localparam int SW = 2;
    localparam int SS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AB-1:0] addr_a, addr_b;
    logic [DB-1:0] din_a, din_b, dout_a, dout_b;
    logic          wr_en_a, wr_en_b;
    logic [SW-1:0] async_in, sync_out, sync_rise;

    dbg_mailbox #(.ADDR_BITS(AB), .DATA_BITS(DB), .SYNC_WIDTH(SW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .din_a(din_a), .wr_en_a(wr_en_a), .dout_a(dout_a),
        .addr_b(addr_b), .din_b(din_b), .wr_en_b(wr_en_b), .dout_b(dout_b),
        .async_in(async_in), .sync_out(sync_out), .sync_rise(sync_rise)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DB-1:0] mem_m [1<<AB];
    logic [DB-1:0] exp_a, exp_b;
    logic [SW-1:0] exp_sync, prev_sync, exp_rise;
    logic          q_rst [$];
    logic [SW-1:0] q_val [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic r,
                        input logic [AB-1:0] aa, input logic [DB-1:0] da, input logic wa,
                        input logic [AB-1:0] ab, input logic [DB-1:0] db, input logic wb,
                        input logic [SW-1:0] ai);
        logic any_rst;
        rst = r; addr_a = aa; din_a = da; wr_en_a = wa;
        addr_b = ab; din_b = db; wr_en_b = wb; async_in = ai;
        @(posedge clk);
        if (r) begin
            exp_a = '0;
            exp_b = '0;
        end else begin
            exp_a = mem_m[aa];
            exp_b = mem_m[ab];
        end
        if (wa) mem_m[aa] = da;
        if (wb) mem_m[ab] = db;
        q_rst.push_back(r);
        q_val.push_back(ai);
        if (q_rst.size() > SS) begin
            q_rst.delete(0);
            q_val.delete(0);
        end
        any_rst = 1'b0;
        foreach (q_rst[i]) any_rst |= q_rst[i];
        exp_sync = (q_rst.size() == SS && !any_rst) ? q_val[0] : '0;
        exp_rise = exp_sync & ~prev_sync;
        prev_sync = exp_sync;
        #1;
        check("dout_a", 64'(dout_a), 64'(exp_a));
        check("dout_b", 64'(dout_b), 64'(exp_b));
        check("sync_out", 64'(sync_out), 64'(exp_sync));
        check("sync_rise", 64'(sync_rise), 64'(exp_rise));
    endtask

    task automatic idle(input logic [SW-1:0] ai);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ai);
    endtask

    initial begin
        int rises;
        logic [SW-1:0] ai;
        foreach (mem_m[i]) mem_m[i] = '0;
        prev_sync = '0;

        repeat (3) step(1'b1, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        check("reset_dout", 64'({dout_a, dout_b}), 64'd0);
        check("reset_sync", 64'({sync_out, sync_rise}), 64'd0);
        idle('0);
        idle('0);

        // Port A writes, port B reads the next cycle.
        step(1'b0, 2'd2, 32'hDEADBEEF, 1'b1, 2'd0, '0, 1'b0, '0);
        step(1'b0, 2'd0, '0, 1'b0, 2'd2, '0, 1'b0, '0);
        check("xport_read", 64'(dout_b), 64'h00000000DEADBEEF);

        // Cross-port read of the address being written returns the old word.
        step(1'b0, 2'd1, 32'h11111111, 1'b1, 2'd1, '0, 1'b0, '0);
        check("xport_old", 64'(dout_b), 64'h0);
        step(1'b0, 2'd0, '0, 1'b0, 2'd1, '0, 1'b0, '0);
        check("xport_new", 64'(dout_b), 64'h0000000011111111);

        // Same-port read-during-write shows the old word.
        step(1'b0, 2'd1, 32'h22222222, 1'b1, 2'd0, '0, 1'b0, '0);
        check("rdw_same", 64'(dout_a), 64'h0000000011111111);

        // Write collision: port B wins.
        step(1'b0, 2'd3, 32'hAAAA0000, 1'b1, 2'd3, 32'h0000BBBB, 1'b1, '0);
        step(1'b0, 2'd3, '0, 1'b0, 2'd3, '0, 1'b0, '0);
        check("collide_a", 64'(dout_a), 64'h000000000000BBBB);

        // Synchronizer latency and single-cycle rise pulse.
        idle(2'b01);
        check("sync_edge0", 64'(sync_out[0]), 64'd0);
        idle(2'b01);
        check("sync_edge1", 64'(sync_out[0]), 64'd1);
        check("rise_edge1", 64'(sync_rise[0]), 64'd1);
        idle(2'b01);
        check("rise_held", 64'(sync_rise[0]), 64'd0);

        // Reset with both inputs held and nonzero read data.
        step(1'b0, 2'd2, '0, 1'b0, 2'd3, '0, 1'b0, 2'b11);
        step(1'b1, 2'd2, '0, 1'b0, 2'd3, '0, 1'b0, 2'b11);
        check("rst_mid_all", 64'({dout_a, dout_b, sync_out, sync_rise}), 64'd0);
        idle(2'b11);
        check("post_rst_1", 64'(sync_rise), 64'd0);
        idle(2'b11);
        check("post_rst_2", 64'(sync_rise), 64'd3);
        idle(2'b11);
        check("post_rst_3", 64'(sync_rise), 64'd0);

        // async_in[1] high, low, high, four cycles per level.
        repeat (4) idle(2'b00);
        rises = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            for (int c = 0; c < 4; c++) begin
                idle((lvl % 2 == 0) ? 2'b10 : 2'b00);
                if (sync_rise[1]) rises++;
            end
        end
        repeat (3) begin
            idle(2'b10);
            if (sync_rise[1]) rises++;
        end
        check("toggle_rises", 64'(rises), 64'd2);

        // Random traffic with held-level async inputs and occasional reset.
        ai = '0;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < SW; b++)
                if ($urandom_range(3) == 0) ai[b] = ~ai[b];
            step(($urandom_range(24) == 0),
                 AB'($urandom), $urandom, 1'($urandom),
                 AB'($urandom), $urandom, 1'($urandom), ai);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
